fpu_mds_arbiter: RTL

- Shares the single FPU multiply/divide/sqrt unit between NUM_REQ requesters, e.g. the core FP issue port and a vector/helper port.
- Accepts one operation at a time with round-robin fairness, pulses the unit's start, and waits for its done.
- Returns the result, flags and tag to the owning requester over a valid/ready response channel.
- Includes a watchdog and illegal-op short-circuit so a requester can never deadlock.

---
 rtl/fpu_mds_arbiter_pkg.sv | 39 +++
 rtl/fpu_rr_picker.sv | 46 ++++
 rtl/fpu_mds_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_mds_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpu_mds_arbiter_pkg
// Purpose : Shared definitions for the FPU mul/div/sqrt arbiter: operation
//           encodings, canonical quiet NaN, exception-flag layout and the
//           arbiter state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package fpu_mds_arbiter_pkg;

  // Operation encodings presented to the shared unit; 2'b11 is illegal.
  localparam logic [1:0] OP_FMUL  = 2'b00;
  localparam logic [1:0] OP_FDIV  = 2'b01;
  localparam logic [1:0] OP_FSQRT = 2'b10;

  // Canonical single-precision quiet NaN.
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Exception flags, packed so that nv is bit 4 down to nx at bit 0.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam fflags_t FLAGS_INVALID = '{nv: 1'b1, default: 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/fpu_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : fpu_rr_picker
// Purpose : Combinational round-robin selector. Scans i_req starting at
//           i_rr_ptr (wrapping) and grants the first set index.
// Ports   : i_req          - request vector
//           i_rr_ptr       - index that has highest priority this cycle
//           o_grant_onehot - one-hot grant (zero when no request)
//           o_grant_idx    - binary index of the grant
//           o_any          - at least one request is set
// Rev     : 1.0  initial release
// ============================================================================
module fpu_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant_onehot,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  int w_j;

  always_comb begin
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    o_any          = 1'b0;
    w_j            = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Rotated index; i_rr_ptr < NUM_REQ so one subtraction wraps it.
      w_j = int'(i_rr_ptr) + k;
      if (w_j >= NUM_REQ) begin
        w_j = w_j - NUM_REQ;
      end
      if (!o_any && i_req[w_j]) begin
        o_any               = 1'b1;
        o_grant_idx         = IDX_W'(w_j);
        o_grant_onehot[w_j] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_mds_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fpu_mds_arbiter
// Purpose : Shares one FPU multiply/divide/sqrt unit between NUM_REQ
//           requesters. One operation in flight; round-robin grant; result,
//           flags and tag returned to the owner on a valid/ready channel.
//           Illegal ops and watchdog expiry complete with qNaN + NV.
// Ports   : clk, reset                 - clock, synchronous active-high reset
//           req_valid/req_ready        - per-requester request handshake
//           req_op/req_a/req_b/req_tag - packed per-requester request fields
//           mds_start/op_sel/a/b       - unit issue interface (held operands)
//           mds_done/result/flags      - unit completion interface
//           rsp_valid/rsp_ready        - per-requester response handshake
//           rsp_result/flags/tag       - shared response payload
//           timeout_err                - one-cycle pulse on watchdog expiry
// Rev     : 1.0  initial release
// ============================================================================
module fpu_mds_arbiter
  import fpu_mds_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [32*NUM_REQ-1:0]    req_a,
  input  logic [32*NUM_REQ-1:0]    req_b,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic                     mds_start,
  output logic [1:0]               mds_op_sel,
  output logic [31:0]              mds_a,
  output logic [31:0]              mds_b,
  input  logic                     mds_done,
  input  logic [31:0]              mds_result,
  input  logic [4:0]               mds_flags,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [31:0]              rsp_result,
  output logic [4:0]               rsp_flags,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  // Registered state
  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [1:0]         r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [TAG_W-1:0]   r_tag;
  logic [31:0]        r_result;
  fflags_t            r_flags;
  logic [WD_W-1:0]    r_wdog;

  // Combinational
  arb_state_e         w_state_nxt;
  logic [NUM_REQ-1:0] w_grant_onehot;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any;
  logic               w_grant;
  logic               w_cap_unit;
  logic               w_cap_nan;
  logic               w_handshake;
  logic               w_sel_illegal;
  logic               w_wdog_exp;
  logic [IDX_W-1:0]   w_rr_next;

  logic [1:0]         w_op_arr  [NUM_REQ];
  logic [31:0]        w_a_arr   [NUM_REQ];
  logic [31:0]        w_b_arr   [NUM_REQ];
  logic [TAG_W-1:0]   w_tag_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_op_arr[g]  = req_op[2*g +: 2];
    assign w_a_arr[g]   = req_a[32*g +: 32];
    assign w_b_arr[g]   = req_b[32*g +: 32];
    assign w_tag_arr[g] = req_tag[TAG_W*g +: TAG_W];
  end

  fpu_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req          (req_valid),
    .i_rr_ptr       (r_rr_ptr),
    .o_grant_onehot (w_grant_onehot),
    .o_grant_idx    (w_grant_idx),
    .o_any          (w_any)
  );

  assign w_sel_illegal = !(w_op_arr[w_grant_idx] inside {OP_FMUL, OP_FDIV, OP_FSQRT});
  assign w_wdog_exp    = (r_wdog == WD_W'(TIMEOUT - 1));
  assign w_rr_next     = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  assign mds_op_sel = r_op;
  assign mds_a      = r_a;
  assign mds_b      = r_b;
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;
  assign rsp_tag    = r_tag;

  // Next state and handshake outputs. Reset forces all strobes low so that
  // nothing is granted or issued while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    mds_start   = 1'b0;
    timeout_err = 1'b0;
    w_grant     = 1'b0;
    w_cap_unit  = 1'b0;
    w_cap_nan   = 1'b0;
    w_handshake = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            req_ready = w_grant_onehot;
            w_grant   = 1'b1;
            if (w_sel_illegal) begin
              // Illegal op never reaches the unit.
              w_cap_nan   = 1'b1;
              w_state_nxt = ST_RESP;
            end else begin
              w_state_nxt = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          mds_start = 1'b1;
          if (mds_done) begin
            w_cap_unit  = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A real completion beats a simultaneous watchdog expiry.
          if (mds_done) begin
            w_cap_unit  = 1'b1;
            w_state_nxt = ST_RESP;
          end else if (w_wdog_exp) begin
            w_cap_nan   = 1'b1;
            timeout_err = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid[r_owner] = 1'b1;
          if (rsp_ready[r_owner]) begin
            w_handshake = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_wdog   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner <= w_grant_idx;
        r_op    <= w_op_arr[w_grant_idx];
        r_a     <= w_a_arr[w_grant_idx];
        r_b     <= w_b_arr[w_grant_idx];
        r_tag   <= w_tag_arr[w_grant_idx];
      end
      if (w_cap_unit) begin
        r_result <= mds_result;
        r_flags  <= fflags_t'(mds_flags);
      end else if (w_cap_nan) begin
        r_result <= QNAN;
        r_flags  <= FLAGS_INVALID;
      end
      if (w_handshake) begin
        r_rr_ptr <= w_rr_next;
      end
      // Watchdog counts the cycles spent in BUSY, starting from zero.
      if (r_state == ST_ISSUE) begin
        r_wdog <= '0;
      end else if (r_state == ST_BUSY) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
